ccd_line_ctrl: RTL and testbench
================================

// Module: ccd_line_ctrl
// PURPOSE
//  Line-timing sequencer for the linear CCD front end. Latches a per-line config,
//  drives the transfer-gate pulse (sh), enables/programs the CCD clock generator
//  (clk_en, f2_freq), and emits pixel ticks and an active-pixel window aligned to
//  f2 periods for the AD9945 capture path. Sits between the register file and the clock generator.
// PARAMETERS
//  PIX_W        14     width of pixel count/index
//  DEF_F2_FREQ  8'd10  f2_freq driven out of reset / while IDLE
//  SETUP_CYC    16     sys_clk cycles sh low before pulse (clocks stopped)
//  HOLD_CYC     16     sys_clk cycles sh low after pulse before clocks restart
// PORTS
//  sys_clk      in   1      system clock (100 MHz)
//  rst          in   1      asynchronous reset, active-high
//  start        in   1      level; sampled in IDLE only
//  cont_mode    in   1      1: repeat lines back-to-back; sampled at each line end
//  stop         in   1      pulse; finish current line then IDLE
//  cfg_f2_freq  in   8      f2 period in sys_clk cycles (legal 4..255)
//  cfg_pix_num  in   PIX_W  active pixels per line (legal >=1)
//  cfg_dummy    in   8      leading dummy pixels (0 allowed)
//  cfg_sh_len   in   16     sh high width in sys_clk cycles (legal >=1)
//  cfg_int_time in   24     idle sys_clk cycles after active window (0 allowed)
//  f2_freq      out  8      divider setting to clock generator
//  clk_en       out  1      gates f2/rs/cp/shp/shd downstream
//  sh           out  1      CCD transfer-gate pulse
//  pix_tick     out  1      1-cycle pulse at start of each dummy/active pixel period
//  line_valid   out  1      high across active pixel periods
//  pix_idx      out  PIX_W  active pixel index, valid while line_valid
//  busy         out  1      high in any state except IDLE
//  line_done    out  1      1-cycle pulse at end of each completed line
//  cfg_err      out  1      1-cycle pulse: start refused due to illegal config
// BEHAVIOUR
//  - All outputs registered. Reset/IDLE values: f2_freq=DEF_F2_FREQ, all others 0.
//  - States: IDLE -> SH_SETUP -> SH_PULSE -> SH_HOLD -> DUMMY -> ACTIVE -> INTEG -> (SH_SETUP|IDLE).
//  - IDLE: start=1 with legal cfg -> latch all cfg_* into shadow regs, enter SH_SETUP;
//    busy=1 the next cycle. Illegal cfg -> stay IDLE, cfg_err pulses 1 cycle, re-checked each cycle start is high.
//  - f2_freq output updates from shadow the cycle after latch; stable for whole line.
//  - SH_SETUP SETUP_CYC cycles; SH_PULSE sh=1 exactly cfg_sh_len cycles; SH_HOLD HOLD_CYC cycles.
//    clk_en=0 in all three.
//  - DUMMY: skipped if cfg_dummy=0; else clk_en=1, cfg_dummy*f2 cycles, pix_tick when
//    8-bit div_cnt==0 (div_cnt 0..f2-1, reset to 0 on DUMMY/ACTIVE entry), line_valid=0.
//  - ACTIVE: clk_en=1, cfg_pix_num*f2 cycles, line_valid=1, pix_tick on div_cnt==0,
//    pix_idx starts 0, increments on div_cnt wrap, never exceeds cfg_pix_num-1.
//  - DUMMY->ACTIVE: div_cnt continuous phase (no gap cycle); first active pix_tick
//    occurs f2 cycles after last dummy tick.
//  - INTEG: clk_en=1, line_valid=0, cfg_int_time cycles (0 -> single transit cycle).
//    On exit line_done pulses 1 cycle.
//  - Line end: if cont_mode=1 and no stop pending -> re-latch cfg (illegal cfg -> cfg_err,
//    IDLE) and go SH_SETUP; else IDLE.
//  - stop in any busy state sets stop_pend; cleared on entering IDLE. stop in IDLE ignored.
//  - cfg_* changes mid-line have no effect until next latch.
//  - Async rst mid-line: all outputs to reset values immediately, no line_done.
// TESTING
//  - Reset: rst high mid-ACTIVE -> same-cycle-async clear: sh=0, clk_en=0, busy=0, f2_freq=10.
//  - Single line f2=10,pix=4,dummy=2,sh_len=5,int=3,cont=0: sh high 5 cycles; 6 pix_ticks
//    10 cycles apart; line_valid high 40 cycles, pix_idx 0..3; line_done once; busy drops.
//  - Odd f2=5, dummy=0, int=0: ACTIVE entered directly after SH_HOLD; ticks every 5 cycles.
//  - Continuous mode, 3 lines, stop pulsed in line 2 ACTIVE -> line 2 completes, line_done x2, IDLE.
//  - cfg_f2_freq=3 or cfg_pix_num=0 with start=1 -> cfg_err pulses, busy stays 0.
//  - Change cfg_pix_num 4->8 mid-line in cont mode -> current line 4 pixels, next line 8.

Source files
------------

// File: rtl/ccd_line_ctrl.sv
// Line-timing sequencer for the linear CCD front end.
// It latches a per-line configuration and generates the transfer-gate pulse,
// the clock-generator enable and divider setting, pixel ticks and the
// active-pixel window.
// All outputs are registered from next-state values, so every output
// lines up with the state register it describes.
module ccd_line_ctrl #(
  parameter int         PIX_W       = 14,
  parameter logic [7:0] DEF_F2_FREQ = 8'd10,
  parameter int         SETUP_CYC   = 16,
  parameter int         HOLD_CYC    = 16
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             stop,
  input  logic [7:0]       cfg_f2_freq,
  input  logic [PIX_W-1:0] cfg_pix_num,
  input  logic [7:0]       cfg_dummy,
  input  logic [15:0]      cfg_sh_len,
  input  logic [23:0]      cfg_int_time,
  output logic [7:0]       f2_freq,
  output logic             clk_en,
  output logic             sh,
  output logic             pix_tick,
  output logic             line_valid,
  output logic [PIX_W-1:0] pix_idx,
  output logic             busy,
  output logic             line_done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DUMMY, S_ACTIVE, S_INTEG
  } state_t;

  localparam logic [23:0] SETUP_LAST = 24'(SETUP_CYC - 1);
  localparam logic [23:0] HOLD_LAST  = 24'(HOLD_CYC - 1);

  state_t           state_q, state_d;
  logic [23:0]      cnt_q, cnt_d;
  logic [7:0]       div_q, div_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             stop_pend_q, stop_pend_d;
  logic             latch, done_d, err_d;

  // Shadow copy of the configuration, held constant for the whole line
  logic [7:0]       f2_sh_q;
  logic [PIX_W-1:0] pixn_sh_q;
  logic [7:0]       dummy_sh_q;
  logic [15:0]      shlen_sh_q;
  logic [23:0]      int_sh_q;

  logic [7:0]       f2_freq_d;
  logic             clk_en_d, sh_d, pix_tick_d, line_valid_d, busy_d;
  logic [PIX_W-1:0] pix_idx_d;

  logic             cfg_ok, div_wrap;
  logic [23:0]      sh_last, int_last;
  logic [PIX_W-1:0] dummy_last, pix_last;

  assign cfg_ok     = (cfg_f2_freq >= 8'd4) && (cfg_pix_num != '0) && (cfg_sh_len != 16'd0);
  assign div_wrap   = (div_q == f2_sh_q - 8'd1);
  assign sh_last    = {8'd0, shlen_sh_q} - 24'd1;
  assign int_last   = int_sh_q - 24'd1;
  assign dummy_last = PIX_W'(dummy_sh_q) - PIX_W'(1);
  assign pix_last   = pixn_sh_q - PIX_W'(1);

  // State register and phase counters
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      pix_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pix_q       <= pix_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Capture the configuration whenever a line is (re)started
  always_ff @(posedge sys_clk) begin
    if (latch) begin
      f2_sh_q    <= cfg_f2_freq;
      pixn_sh_q  <= cfg_pix_num;
      dummy_sh_q <= cfg_dummy;
      shlen_sh_q <= cfg_sh_len;
      int_sh_q   <= cfg_int_time;
    end
  end

  // Next-state sequencing through the line phases
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pix_d   = pix_q;
    latch   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            latch   = 1'b1;
            state_d = S_SETUP;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 24'd1;
      end
      S_PULSE: begin
        if (cnt_q == sh_last) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 24'd1;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = (dummy_sh_q == 8'd0) ? S_ACTIVE : S_DUMMY;
          cnt_d   = '0;
          div_d   = '0;
          pix_d   = '0;
        end else cnt_d = cnt_q + 24'd1;
      end
      S_DUMMY: begin
        // Divider phase runs straight into ACTIVE without a gap cycle
        if (div_wrap) begin
          div_d = '0;
          if (pix_q == dummy_last) begin
            state_d = S_ACTIVE;
            pix_d   = '0;
          end else pix_d = pix_q + PIX_W'(1);
        end else div_d = div_q + 8'd1;
      end
      S_ACTIVE: begin
        if (div_wrap) begin
          div_d = '0;
          if (pix_q == pix_last) begin
            state_d = S_INTEG;
            pix_d   = '0;
            cnt_d   = '0;
          end else pix_d = pix_q + PIX_W'(1);
        end else div_d = div_q + 8'd1;
      end
      S_INTEG: begin
        // A zero integration time still spends one transit cycle here
        if ((int_sh_q == 24'd0) || (cnt_q == int_last)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (cont_mode && !(stop_pend_q || stop)) begin
            if (cfg_ok) begin
              latch   = 1'b1;
              state_d = S_SETUP;
              cnt_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end else cnt_d = cnt_q + 24'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so outputs align with state_q
  always_comb begin
    stop_pend_d  = (state_d == S_IDLE) ? 1'b0
                 : (stop_pend_q || (stop && (state_q != S_IDLE)));
    busy_d       = (state_d != S_IDLE);
    sh_d         = (state_d == S_PULSE);
    clk_en_d     = (state_d == S_DUMMY) || (state_d == S_ACTIVE) || (state_d == S_INTEG);
    line_valid_d = (state_d == S_ACTIVE);
    pix_tick_d   = ((state_d == S_DUMMY) || (state_d == S_ACTIVE)) && (div_d == 8'd0);
    pix_idx_d    = (state_d == S_ACTIVE) ? pix_d : '0;
    // Divider setting follows the shadow one cycle after it is latched
    f2_freq_d    = ((state_d == S_IDLE) || (state_q == S_IDLE)) ? DEF_F2_FREQ : f2_sh_q;
  end

  // Output registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      f2_freq    <= DEF_F2_FREQ;
      clk_en     <= 1'b0;
      sh         <= 1'b0;
      pix_tick   <= 1'b0;
      line_valid <= 1'b0;
      pix_idx    <= '0;
      busy       <= 1'b0;
      line_done  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      f2_freq    <= f2_freq_d;
      clk_en     <= clk_en_d;
      sh         <= sh_d;
      pix_tick   <= pix_tick_d;
      line_valid <= line_valid_d;
      pix_idx    <= pix_idx_d;
      busy       <= busy_d;
      line_done  <= done_d;
      cfg_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_ccd_line_ctrl.sv
// Directed bench for ccd_line_ctrl with a pixel-tick scoreboard.
module tb_ccd_line_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, cont_mode, stop;
  logic [7:0]  cfg_f2_freq, cfg_dummy;
  logic [13:0] cfg_pix_num;
  logic [15:0] cfg_sh_len;
  logic [23:0] cfg_int_time;
  logic [7:0]  f2_freq;
  logic        clk_en, sh, pix_tick, line_valid, busy, line_done, cfg_err;
  logic [13:0] pix_idx;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { bit lv; int idx; int gap; } exp_t;
  exp_t exp_q[$];

  ccd_line_ctrl dut (
    .sys_clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode), .stop(stop),
    .cfg_f2_freq(cfg_f2_freq), .cfg_pix_num(cfg_pix_num), .cfg_dummy(cfg_dummy),
    .cfg_sh_len(cfg_sh_len), .cfg_int_time(cfg_int_time),
    .f2_freq(f2_freq), .clk_en(clk_en), .sh(sh), .pix_tick(pix_tick),
    .line_valid(line_valid), .pix_idx(pix_idx), .busy(busy),
    .line_done(line_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected tick sequence of one line; gap -1 means first tick of a line
  task automatic push_line(input int f2, input int dum, input int pix);
    for (int i = 0; i < dum; i++) exp_q.push_back('{1'b0, 0, (i == 0) ? -1 : f2});
    for (int i = 0; i < pix; i++) exp_q.push_back('{1'b1, i, (dum == 0 && i == 0) ? -1 : f2});
  endtask

  task automatic set_cfg(input int f2, input int pix, input int dum, input int shl, input int it);
    cfg_f2_freq  = 8'(f2);
    cfg_pix_num  = 14'(pix);
    cfg_dummy    = 8'(dum);
    cfg_sh_len   = 16'(shl);
    cfg_int_time = 24'(it);
  endtask

  // Watch the DUT until busy drops; action codes: 1 pulse stop, 2 set pix_num=8
  task automatic watch(input int maxc, input int exp_f2,
                       input int a1_tick, input int a1_code,
                       input int a2_tick, input int a2_code,
                       output int bc, output int shc, output int lvc,
                       output int ldc, output int tc, output int bad);
    int since;
    bit finished;
    exp_t e;
    since = 0; finished = 0;
    bc = 0; shc = 0; lvc = 0; ldc = 0; tc = 0; bad = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (stop) stop = 1'b0;
      since++;
      if (busy) bc++;
      if (sh) shc++;
      if (line_valid) lvc++;
      if (line_done) ldc++;
      if (sh && clk_en) bad++;
      if (clk_en && f2_freq != 8'(exp_f2)) bad++;
      if (pix_tick) begin
        tc++;
        if (exp_q.size() == 0) chk("tick_extra", 32'(tc), 0);
        else begin
          e = exp_q.pop_front();
          chk("tick_lv", 32'(line_valid), 32'(e.lv));
          if (e.lv) chk("tick_idx", 32'(pix_idx), 32'(e.idx));
          if (e.gap > 0) chk("tick_gap", 32'(since), 32'(e.gap));
        end
        since = 0;
        if (tc == a1_tick) begin
          if (a1_code == 1) stop = 1'b1; else if (a1_code == 2) cfg_pix_num = 14'd8;
        end
        if (tc == a2_tick) begin
          if (a2_code == 1) stop = 1'b1; else if (a2_code == 2) cfg_pix_num = 14'd8;
        end
      end
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    chk("watch_done", 32'(finished), 1);
    chk("sb_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bc, shc, lvc, ldc, tc, bad, n;
    rst = 1'b1; start = 1'b0; cont_mode = 1'b0; stop = 1'b0;
    set_cfg(10, 4, 2, 5, 3);
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sh", 32'(sh), 0);
    chk("rst_clk_en", 32'(clk_en), 0);
    chk("rst_f2", 32'(f2_freq), 10);
    chk("rst_lv", 32'(line_valid), 0);
    chk("rst_tick", 32'(pix_tick), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single line f2=10 pix=4 dummy=2 sh=5 int=3
    push_line(10, 2, 4);
    kick();
    chk("l1_busy_up", 32'(busy), 1);
    watch(400, 10, 0, 0, 0, 0, bc, shc, lvc, ldc, tc, bad);
    chk("l1_busy_cyc", 32'(bc + 1), 100);
    chk("l1_sh_cyc", 32'(shc), 5);
    chk("l1_lv_cyc", 32'(lvc), 40);
    chk("l1_done", 32'(ldc), 1);
    chk("l1_ticks", 32'(tc), 6);
    chk("l1_bad", 32'(bad), 0);
    chk("l1_f2_idle", 32'(f2_freq), 10);

    // f2=5, no dummies, zero integration time
    set_cfg(5, 4, 0, 5, 0);
    push_line(5, 0, 4);
    kick();
    chk("l2_busy_up", 32'(busy), 1);
    chk("l2_f2_latch", 32'(f2_freq), 10);
    @(negedge clk);
    chk("l2_f2_upd", 32'(f2_freq), 5);
    watch(400, 5, 0, 0, 0, 0, bc, shc, lvc, ldc, tc, bad);
    chk("l2_busy_cyc", 32'(bc + 2), 58);
    chk("l2_sh_cyc", 32'(shc), 5);
    chk("l2_lv_cyc", 32'(lvc), 20);
    chk("l2_done", 32'(ldc), 1);
    chk("l2_ticks", 32'(tc), 4);
    chk("l2_bad", 32'(bad), 0);

    // Continuous mode, stop during line 2 ACTIVE
    cont_mode = 1'b1;
    set_cfg(4, 3, 1, 2, 2);
    push_line(4, 1, 3);
    push_line(4, 1, 3);
    kick();
    watch(800, 4, 6, 1, 0, 0, bc, shc, lvc, ldc, tc, bad);
    chk("c_busy_cyc", 32'(bc + 1), 104);
    chk("c_sh_cyc", 32'(shc), 4);
    chk("c_lv_cyc", 32'(lvc), 24);
    chk("c_done", 32'(ldc), 2);
    chk("c_ticks", 32'(tc), 8);
    chk("c_bad", 32'(bad), 0);

    // Mid-line pix_num change applies to the next line only
    set_cfg(4, 4, 0, 1, 0);
    push_line(4, 0, 4);
    push_line(4, 0, 8);
    kick();
    watch(800, 4, 2, 2, 6, 1, bc, shc, lvc, ldc, tc, bad);
    chk("p_busy_cyc", 32'(bc + 1), 116);
    chk("p_lv_cyc", 32'(lvc), 48);
    chk("p_done", 32'(ldc), 2);
    chk("p_ticks", 32'(tc), 12);
    chk("p_bad", 32'(bad), 0);
    cont_mode = 1'b0;

    // Illegal configurations refused
    set_cfg(3, 4, 0, 1, 0);
    start = 1'b1;
    @(negedge clk);
    chk("e1_err", 32'(cfg_err), 1);
    chk("e1_busy", 32'(busy), 0);
    @(negedge clk);
    chk("e1_err_again", 32'(cfg_err), 1);
    start = 1'b0;
    @(negedge clk);
    chk("e1_err_off", 32'(cfg_err), 0);
    set_cfg(10, 0, 0, 1, 0);
    kick();
    chk("e2_err", 32'(cfg_err), 1);
    chk("e2_busy", 32'(busy), 0);
    @(negedge clk);
    chk("e2_err_off", 32'(cfg_err), 0);
    chk("e2_busy_off", 32'(busy), 0);

    // Asynchronous reset in the middle of ACTIVE
    set_cfg(10, 4, 0, 2, 3);
    kick();
    n = 0;
    while (!line_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("r_reach_active", 32'(line_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("r_sh", 32'(sh), 0);
    chk("r_clk_en", 32'(clk_en), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_f2", 32'(f2_freq), 10);
    chk("r_lv", 32'(line_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    ldc = 0; bc = 0;
    repeat (20) begin
      @(negedge clk);
      if (line_done) ldc++;
      if (busy) bc++;
    end
    chk("r_no_done", 32'(ldc), 0);
    chk("r_stay_idle", 32'(bc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
